jtopl_timers: RTL and testbench

Timer A/B block directly downstream of the register map. It consumes value_A/B, load_A/B, flagen_A/B and clr_flag_A/B. It produces flag_A, flag_B, overflow_A (for CSM key-on), the IRQ line and the status-byte bits. Timing derives from cenop and the zero slot marker, so one tick equals one sample (18 slots).

---
 rtl/jtopl_timers_pkg.sv | 18 +
 rtl/jtopl_timers_cnt.sv | 45 ++++
 rtl/jtopl_timers.sv | 78 +++++++
 tb/tb_jtopl_timers.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_timers_pkg.sv
// Shared constants for the OPL timer block.
// Status byte bit positions and a helper to assemble the status byte.
package jtopl_timers_pkg;

    localparam int STAT_IRQ = 7;
    localparam int STAT_FT1 = 6;
    localparam int STAT_FT2 = 5;

    function automatic logic [7:0] status_byte(input logic fa, input logic fb);
        logic [7:0] s;
        s           = 8'h00;
        s[STAT_IRQ] = fa | fb;
        s[STAT_FT1] = fa;
        s[STAT_FT2] = fb;
        return s;
    endfunction

endpackage

// File: rtl/jtopl_timers_cnt.sv
// One OPL timer: 8-bit up-counter with load edge detect,
// sticky flag (clear wins over set) and one-cenop overflow pulse.
module jtopl_timer_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       tick,
    input  logic [7:0] value,
    input  logic       load,
    input  logic       flagen,
    input  logic       clr_flag,
    output logic       flag,
    output logic       overflow
);

    logic [7:0] cnt;
    logic       load_l;
    logic       start;
    logic       ovf;

    // A start cycle only reloads; it never counts.
    assign start = load & ~load_l;
    assign ovf   = load & tick & ~start & (cnt == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 8'h00;
            load_l   <= 1'b0;
            flag     <= 1'b0;
            overflow <= 1'b0;
        end else if (cenop) begin
            load_l   <= load;
            overflow <= ovf;
            if (start)
                cnt <= value;
            else if (load & tick)
                cnt <= ovf ? value : cnt + 8'd1;
            if (clr_flag)
                flag <= 1'b0;
            else if (ovf & flagen)
                flag <= 1'b1;
        end
    end

endmodule

// File: rtl/jtopl_timers.sv
// OPL Timer A/B block: sample prescaler, two timers, IRQ and status.
// One prescaler step per sample (cenop & zero).
module jtopl_timers
    import jtopl_timers_pkg::*;
#(
    parameter int PRE_A = 4,
    parameter int PRE_B = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       zero,
    input  logic [7:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       flagen_A,
    input  logic       flagen_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n,
    output logic [7:0] status
);

    localparam int LA = $clog2(PRE_A);

    logic [3:0] pre;
    logic       tick_A;
    logic       tick_B;
    logic       overflow_B;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pre <= 4'd0;
        else if (cenop & zero)
            pre <= pre + 4'd1;
    end

    assign tick_A = cenop & zero & (&pre[LA-1:0]);
    assign tick_B = cenop & zero & (pre == 4'(PRE_B - 1));

    jtopl_timer_cnt u_timer_a (
        .clk      (clk),
        .rst      (rst),
        .cenop    (cenop),
        .tick     (tick_A),
        .value    (value_A),
        .load     (load_A),
        .flagen   (flagen_A),
        .clr_flag (clr_flag_A),
        .flag     (flag_A),
        .overflow (overflow_A)
    );

    // Timer B has no CSM role, so its overflow pulse is left unused.
    jtopl_timer_cnt u_timer_b (
        .clk      (clk),
        .rst      (rst),
        .cenop    (cenop),
        .tick     (tick_B),
        .value    (value_B),
        .load     (load_B),
        .flagen   (flagen_B),
        .clr_flag (clr_flag_B),
        .flag     (flag_B),
        .overflow (overflow_B)
    );

    assign irq_n  = ~(flag_A | flag_B);
    assign status = status_byte(flag_A, flag_B);

    logic unused_ok;
    assign unused_ok = overflow_B;

endmodule

// File: tb/tb_jtopl_timers.sv
// Bench for jtopl_timers: tick-level reference model compared every cycle,
// plus directed literal checks of periods, status codes and reset.
module tb_jtopl_timers;

    localparam int PRE_A = 4;
    localparam int PRE_B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic       zero = 1'b0;
    logic [7:0] value_A = 8'h00;
    logic [7:0] value_B = 8'h00;
    logic       load_A = 1'b0;
    logic       load_B = 1'b0;
    logic       flagen_A = 1'b0;
    logic       flagen_B = 1'b0;
    logic       clr_flag_A = 1'b0;
    logic       clr_flag_B = 1'b0;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic       irq_n;
    logic [7:0] status;

    int checks = 0;
    int failures = 0;

    jtopl_timers #(.PRE_A(PRE_A), .PRE_B(PRE_B)) dut (
        .clk        (clk),
        .rst        (rst),
        .cenop      (cenop),
        .zero       (zero),
        .value_A    (value_A),
        .value_B    (value_B),
        .load_A     (load_A),
        .load_B     (load_B),
        .flagen_A   (flagen_A),
        .flagen_B   (flagen_B),
        .clr_flag_A (clr_flag_A),
        .clr_flag_B (clr_flag_B),
        .flag_A     (flag_A),
        .flag_B     (flag_B),
        .overflow_A (overflow_A),
        .irq_n      (irq_n),
        .status     (status)
    );

    always #5 clk = ~clk;

    // cenop every other clock, a sample marker every third cenop
    int gen_cyc = 0;
    int gen_ce = 0;
    always @(posedge clk) begin
        #1;
        gen_cyc++;
        cenop = (gen_cyc % 2) == 0;
        if (cenop) begin
            zero = (gen_ce % 3) == 0;
            gen_ce++;
        end else begin
            zero = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each timer tracks ticks remaining until overflow
    int m_samp;
    bit m_prev [2];
    int m_rem  [2];
    bit m_flag [2];
    bit m_ovfA;

    always @(posedge clk or posedge rst) begin : model
        int  rem;
        int  per;
        bit  tk, st, ov, fl;
        int  val [2];
        bit  ld  [2];
        bit  fe  [2];
        bit  cl  [2];
        if (rst) begin
            m_samp  <= 0;
            m_prev  <= '{0, 0};
            m_rem   <= '{256, 256};
            m_flag  <= '{0, 0};
            m_ovfA  <= 0;
        end else if (cenop) begin
            val = '{int'(value_A), int'(value_B)};
            ld  = '{load_A, load_B};
            fe  = '{flagen_A, flagen_B};
            cl  = '{clr_flag_A, clr_flag_B};
            for (int t = 0; t < 2; t++) begin
                per = (t == 0) ? PRE_A : PRE_B;
                tk  = zero && ((m_samp % per) == per - 1);
                st  = ld[t] && !m_prev[t];
                rem = m_rem[t];
                ov  = 0;
                if (st) begin
                    rem = 256 - val[t];
                end else if (ld[t] && tk) begin
                    rem = rem - 1;
                    if (rem == 0) begin
                        ov  = 1;
                        rem = 256 - val[t];
                    end
                end
                fl = m_flag[t];
                if (cl[t])
                    fl = 0;
                else if (ov && fe[t])
                    fl = 1;
                m_rem[t]  <= rem;
                m_flag[t] <= fl;
                m_prev[t] <= ld[t];
                if (t == 0)
                    m_ovfA <= ov;
            end
            if (zero)
                m_samp <= (m_samp + 1) % 16;
        end
    end

    int ovA_cnt = 0;
    always @(negedge clk) begin : compare
        int est;
        est = (m_flag[0] || m_flag[1]) ? 128 : 0;
        est += m_flag[0] ? 64 : 0;
        est += m_flag[1] ? 32 : 0;
        chk("flag_A", int'(flag_A), int'(m_flag[0]));
        chk("flag_B", int'(flag_B), int'(m_flag[1]));
        chk("overflow_A", int'(overflow_A), int'(m_ovfA));
        chk("irq_n", int'(irq_n), (m_flag[0] || m_flag[1]) ? 0 : 1);
        chk("status", int'(status), est);
        if (overflow_A)
            ovA_cnt++;
    end

    task automatic wait_samples(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (cenop && zero)
                k++;
        end
        #1;
    endtask

    // Samples elapsed until overflow_A next rises; timeout counts as failure
    task automatic wait_ovfA(output int n);
        int  b = 0;
        bit  ok = 0;
        n = 0;
        while (overflow_A && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        b = 0;
        while (!ok && b < 4000) begin
            @(posedge clk);
            if (cenop && zero)
                n++;
            #1;
            b++;
            if (overflow_A)
                ok = 1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_ovfA timeout actual=none required=pulse at %0t", $time);
        end
    endtask

    initial begin
        int n;
        int c0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", int'(status), 0);
        chk("rst_irq_n", int'(irq_n), 1);
        rst = 1'b0;

        // idle: nothing running
        c0 = ovA_cnt;
        wait_samples(2000);
        chk("idle_ovfA_pulses", ovA_cnt - c0, 0);
        chk("idle_status", int'(status), 0);
        chk("idle_irq_n", int'(irq_n), 1);

        // Timer B with flag disabled, then enabled
        value_B = 8'hFF;
        load_B  = 1'b1;
        wait_samples(64);
        chk("B_noflag_flag_B", int'(flag_B), 0);
        chk("B_noflag_irq_n", int'(irq_n), 1);
        flagen_B = 1'b1;
        wait_samples(17);
        chk("B_flag_B", int'(flag_B), 1);
        chk("B_status", int'(status), 8'hA0);
        flagen_B   = 1'b0;
        load_B     = 1'b0;
        clr_flag_B = 1'b1;
        wait_samples(2);
        clr_flag_B = 1'b0;
        chk("B_cleared_status", int'(status), 0);

        // Timer A, value FC: 4 ticks per period
        value_A  = 8'hFC;
        flagen_A = 1'b1;
        load_A   = 1'b1;
        wait_ovfA(n);
        chk("A_first_ovf_in_13_17", int'(n >= 13 && n <= 17), 1);
        chk("A_status", int'(status), 8'hC0);
        chk("A_irq_n", int'(irq_n), 0);
        wait_ovfA(n);
        chk("A_period", n, 16);

        // clear held across an overflow wins, later overflow sets again
        clr_flag_A = 1'b1;
        wait_ovfA(n);
        chk("A_clr_prio_flag_A", int'(flag_A), 0);
        clr_flag_A = 1'b0;
        wait_ovfA(n);
        chk("A_reset_after_clr", int'(flag_A), 1);

        // stop mid-count, restart must reload rather than resume
        load_A  = 1'b0;
        value_A = 8'h00;
        wait_samples(2);
        load_A = 1'b1;
        wait_samples(512);
        load_A = 1'b0;
        wait_samples(100);
        value_A = 8'hFC;
        load_A  = 1'b1;
        wait_ovfA(n);
        chk("A_restart_in_13_17", int'(n >= 13 && n <= 17), 1);

        // async reset while flag_A and overflow_A are high
        wait_ovfA(n);
        chk("pre_rst_flag_A", int'(flag_A), 1);
        chk("pre_rst_ovfA", int'(overflow_A), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_flag_A", int'(flag_A), 0);
        chk("async_ovfA", int'(overflow_A), 0);
        chk("async_irq_n", int'(irq_n), 1);
        chk("async_status", int'(status), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized operation against the model
        for (int i = 0; i < 8000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 99) < 2) load_A = ~load_A;
            if ($urandom_range(0, 99) < 2) load_B = ~load_B;
            if ($urandom_range(0, 99) < 1) flagen_A = ~flagen_A;
            if ($urandom_range(0, 99) < 1) flagen_B = ~flagen_B;
            if ($urandom_range(0, 99) < 3) value_A = 8'($urandom_range(236, 255));
            if ($urandom_range(0, 99) < 3) value_B = 8'($urandom_range(248, 255));
            clr_flag_A = $urandom_range(0, 99) < 3;
            clr_flag_B = $urandom_range(0, 99) < 3;
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
